// File: rtl/rf_pkg.sv
// rf_pkg: shared clear-engine state encoding and default register file geometry.
package rf_pkg;
  typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rfState_t;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DEPTH = 2 ** DEFAULT_ADDR_WIDTH;
endpackage

// File: rtl/rf_clear_sequencer.sv
// rf_clear_sequencer: walks every register index once, one per cycle, after a clear request.
module rf_clear_sequencer
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ClearReq,
  output logic                  Busy,
  output logic                  ClrEn,
  output logic [ADDR_WIDTH-1:0] ClrIndex
);
  rfState_t state, stateNext;
  logic [ADDR_WIDTH-1:0] indexNext;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state    <= RF_IDLE;
      ClrIndex <= '0;
    end else begin
      state    <= stateNext;
      ClrIndex <= indexNext;
    end
  // The last index is all-ones, so the increment wraps the index back to 0 on exit.
  always_comb begin
    stateNext = state;
    indexNext = ClrIndex;
    if (state == RF_IDLE) begin
      stateNext = ClearReq ? RF_CLEAR : RF_IDLE;
      indexNext = '0;
    end else begin
      indexNext = ADDR_WIDTH'(ClrIndex + 1'b1);
      stateNext = (&ClrIndex) ? RF_IDLE : RF_CLEAR;
    end
  end
  assign Busy  = (state == RF_CLEAR);
  assign ClrEn = Busy;
endmodule

// File: rtl/register_file_bypass.sv
// register_file_bypass: 2-read/1-write register file with write bypass, optional zero register and clear engine.
module register_file_bypass
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  ClearReq,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  clrEn;
  logic [ADDR_WIDTH-1:0] clrIndex;
  logic                  writeOk;
  rf_clear_sequencer #(.ADDR_WIDTH(ADDR_WIDTH)) sequencer (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .ClrEn    (clrEn),
    .ClrIndex (clrIndex)
  );
  assign writeOk = RegWrite && !Busy && !(ZERO_REG != 0 && WriteRegister == '0);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (clrEn)
      regs[clrIndex] <= '0;
    else if (writeOk)
      regs[WriteRegister] <= WriteData;
  // Reset forces zero on the read ports so a bypassed write cannot leak out while it is held.
  always_comb
    ReadData1 = (Reset || (ZERO_REG != 0 && ReadRegister1 == '0)) ? '0 :
                (BYPASS != 0 && writeOk && WriteRegister == ReadRegister1) ? WriteData :
                regs[ReadRegister1];
  always_comb
    ReadData2 = (Reset || (ZERO_REG != 0 && ReadRegister2 == '0)) ? '0 :
                (BYPASS != 0 && writeOk && WriteRegister == ReadRegister2) ? WriteData :
                regs[ReadRegister2];
endmodule
